// File: rtl/snake_pkg.sv
// Shared direction codes, direction type and FSM state type for the snake head stepper.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package snake_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_NONE    = 3'b000;
  localparam dir_t DIR_UP      = 3'b001;
  localparam dir_t DIR_DOWN    = 3'b010;
  localparam dir_t DIR_LEFT    = 3'b011;
  localparam dir_t DIR_RIGHT   = 3'b100;
  localparam dir_t DIR_RESTART = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // True for the four movement codes.
  function automatic logic is_move(dir_t d);
    return (d >= DIR_UP) && (d <= DIR_RIGHT);
  endfunction

  // Reverse direction; DIR_NONE for anything that is not a movement code.
  function automatic dir_t opposite(dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/step_ticker.sv
// Movement tick divider: counts 0..TICK_DIV-1 and flags the terminal count.
// Latency: terminal is combinational from the count register, asserted once per TICK_DIV unheld clocks.
// Backpressure: hold freezes the count and masks terminal; clear forces the count to 0 and masks terminal.
// Ports: clk, rst_n (async active-low), clear, hold -> terminal.
module step_ticker #(
  parameter  int TICK_DIV = 25_000_000,
  localparam int CW       = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic terminal
);

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign terminal = !clear && !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: moves the head one grid cell every TICK_DIV clocks in the last accepted direction.
// Latency: head/step update TICK_DIV clocks after RUN entry or the previous step; restart takes effect on the next edge.
// Backpressure: none; pause freezes the tick counter but direction sampling and restart continue.
// Ports: clk, rst_n, dir_in[2:0], pause -> head_x, head_y, dir_cur[2:0], step, dead.
// Build option: define SNAKE_WRAP_EN to wrap the head around grid edges instead of dying on them.
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter  int GRID_W   = 40,
  parameter  int GRID_H   = 30,
  parameter  int TICK_DIV = 25_000_000,
  localparam int XW       = $clog2(GRID_W),
  localparam int YW       = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    dir_in,
  input  logic          pause,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [2:0]    dir_cur,
  output logic          step,
  output logic          dead
);

  localparam logic [XW-1:0] X_MID = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_MID = YW'(GRID_H / 2);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  state_t        state;
  dir_t          pending;
  logic          term;
  logic          accept;
  dir_t          nd;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          wall;

  // Counter only runs in RUN; a restart code clears it so a coincident terminal never fires.
  step_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    ((state != RUN) || (dir_in == DIR_RESTART)),
    .hold     (pause),
    .terminal (term)
  );

  // Opposite is judged against the applied direction, so a U-turn cannot sneak in
  // via an intermediate pending code. A code accepted in the terminal cycle counts.
  always_comb begin
    accept = is_move(dir_in) && (dir_in != opposite(dir_cur));
    nd     = accept ? dir_in : pending;
    nx     = head_x;
    ny     = head_y;
    wall   = 1'b0;
    case (nd)
      DIR_UP: begin
        if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
          ny = Y_MAX;
`else
          wall = 1'b1;
`endif
        end else begin
          ny = head_y - YW'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
          ny = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          ny = head_y + YW'(1);
        end
      end
      DIR_LEFT: begin
        if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
          nx = X_MAX;
`else
          wall = 1'b1;
`endif
        end else begin
          nx = head_x - XW'(1);
        end
      end
      DIR_RIGHT: begin
        if (head_x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
          nx = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          nx = head_x + XW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      head_x  <= X_MID;
      head_y  <= Y_MID;
      dir_cur <= DIR_NONE;
      pending <= DIR_NONE;
      step    <= 1'b0;
      dead    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (dir_in == DIR_RESTART) begin
        state   <= IDLE;
        head_x  <= X_MID;
        head_y  <= Y_MID;
        dir_cur <= DIR_NONE;
        pending <= DIR_NONE;
        dead    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (is_move(dir_in)) begin
              dir_cur <= dir_in;
              pending <= dir_in;
              state   <= RUN;
            end
          end
          RUN: begin
            if (term) begin
              dir_cur <= nd;
              pending <= nd;
              step    <= 1'b1;
              if (wall) begin
                // Head stays on the edge cell it tried to leave.
                dead  <= 1'b1;
                state <= DEAD;
              end else begin
                head_x <= nx;
                head_y <= ny;
              end
            end else if (accept) begin
              pending <= dir_in;
            end
          end
          DEAD:    ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
module tb_snake_head_stepper;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dir_in;
  logic       pause;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic [2:0] dir_cur;
  logic       step;
  logic       dead;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  snake_head_stepper #(.GRID_W(W), .GRID_H(H), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dir_in  (dir_in),
    .pause   (pause),
    .head_x  (head_x),
    .head_y  (head_y),
    .dir_cur (dir_cur),
    .step    (step),
    .dead    (dead)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for first direction, 1 moving, 2 crashed
  int m_mode = 0;
  int m_x    = W / 2;
  int m_y    = H / 2;
  int m_d    = 0;
  int m_p    = 0;
  int m_cnt  = 0;
  bit m_step = 1'b0;
  bit m_dead = 1'b0;
  int m_nx, m_ny, m_in;

  function automatic bit is_mv(int d);
    return (d >= 1) && (d <= 4);
  endfunction

  function automatic int opp(int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int dx(int d);
    return (d == 3) ? -1 : ((d == 4) ? 1 : 0);
  endfunction

  function automatic int dy(int d);
    return (d == 1) ? -1 : ((d == 2) ? 1 : 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = W / 2; m_y = H / 2; m_d = 0; m_p = 0;
    m_cnt = 0; m_step = 1'b0; m_dead = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_in   = int'(dir_in);
      m_step = 1'b0;
      if (m_in == 7) begin
        model_reset();
      end else if (m_mode == 0) begin
        if (is_mv(m_in)) begin
          m_d = m_in; m_p = m_in; m_mode = 1; m_cnt = 0;
        end
      end else if (m_mode == 1) begin
        if (is_mv(m_in) && m_in != opp(m_d)) m_p = m_in;
        if (!pause) begin
          if (m_cnt == TD - 1) begin
            m_cnt  = 0;
            m_d    = m_p;
            m_step = 1'b1;
            m_nx   = m_x + dx(m_d);
            m_ny   = m_y + dy(m_d);
            if (m_nx < 0 || m_nx >= W || m_ny < 0 || m_ny >= H) begin
`ifdef SNAKE_WRAP_EN
              m_x = (m_nx + W) % W;
              m_y = (m_ny + H) % H;
`else
              m_dead = 1'b1;
              m_mode = 2;
`endif
            end else begin
              m_x = m_nx;
              m_y = m_ny;
            end
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      n_chk++;
      if (int'(head_x) == m_x && int'(head_y) == m_y && int'(dir_cur) == m_d &&
          step == m_step && dead == m_dead)
        n_pass++;
      else
        $display("FAIL model_cmp t=%0t got x=%0d y=%0d dir=%0d step=%0b dead=%0b want x=%0d y=%0d dir=%0d step=%0b dead=%0b",
                 $time, head_x, head_y, dir_cur, step, dead, m_x, m_y, m_d, m_step, m_dead);
    end
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic chk_home(input string name);
    chk({name, "_x"}, int'(head_x), 4);
    chk({name, "_y"}, int'(head_y), 3);
    chk({name, "_dir"}, int'(dir_cur), 0);
    chk({name, "_step"}, int'(step), 0);
    chk({name, "_dead"}, int'(dead), 0);
  endtask

  // Negedges until step is seen (bounded); 40 signals a timeout.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step && n < 40);
  endtask

  task automatic count_steps(input int cycles, output int s);
    s = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (step) s++;
    end
  endtask

  task automatic go(input logic [2:0] d);
    dir_in = d;
    @(negedge clk);
    dir_in = 3'b000;
  endtask

  int n, s;

  initial begin
    rst_n  = 1'b0;
    dir_in = 3'b000;
    pause  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk_home("reset");

    // Right from centre: first step 4 clocks after RUN entry, then every 4.
    go(3'b100);
    wait_step(n);
    chk("lat_first", n, 4);
    chk("r1_x", int'(head_x), 5);
    chk("r1_dir", int'(dir_cur), 4);
    wait_step(n);
    chk("lat_r2", n, 4);
    chk("r2_x", int'(head_x), 6);
    wait_step(n);
    chk("r3_x", int'(head_x), 7);
    chk("r3_y", int'(head_y), 3);

    // Right edge.
    wait_step(n);
    chk("edge_lat", n, 4);
`ifdef SNAKE_WRAP_EN
    chk("edge_x", int'(head_x), 0);
    chk("edge_dead", int'(dead), 0);
    count_steps(12, s);
    chk("after_edge_steps", s, 3);
`else
    chk("edge_x", int'(head_x), 7);
    chk("edge_step", int'(step), 1);
    chk("edge_dead", int'(dead), 1);
    count_steps(12, s);
    chk("after_edge_steps", s, 0);
    chk("after_edge_x", int'(head_x), 7);
`endif

    // Restart from crash/run.
    go(3'b111);
    chk_home("restart1");
    @(negedge clk);

    // Opposite code ignored, later valid code wins.
    go(3'b100);
    wait_step(n);
    chk("t2_x", int'(head_x), 5);
    dir_in = 3'b011;
    @(negedge clk);
    dir_in = 3'b001;
    @(negedge clk);
    dir_in = 3'b000;
    wait_step(n);
    chk("turn_lat", n, 2);
    chk("turn_dir", int'(dir_cur), 1);
    chk("turn_x", int'(head_x), 5);
    chk("turn_y", int'(head_y), 2);

    // Pause for 10 clocks with one count already elapsed.
    @(negedge clk);
    pause = 1'b1;
    count_steps(10, s);
    pause = 1'b0;
    chk("pause_steps", s, 0);
    chk("pause_y", int'(head_y), 2);
    wait_step(n);
    chk("pause_resume_lat", n, 3);
    chk("pause_resume_y", int'(head_y), 1);

    // Restart coinciding with the terminal count.
    repeat (3) @(negedge clk);
    go(3'b111);
    chk_home("restart_term");
    count_steps(8, s);
    chk("idle_steps", s, 0);

    // Asynchronous reset mid-run.
    go(3'b010);
    wait_step(n);
    chk("down_y", int'(head_y), 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_home("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Top edge: 3 moves up to row 0, the 4th hits the wall.
    go(3'b001);
    for (int i = 0; i < 4; i++) wait_step(n);
`ifdef SNAKE_WRAP_EN
    chk("top_y", int'(head_y), 5);
    chk("top_dead", int'(dead), 0);
`else
    chk("top_y", int'(head_y), 0);
    chk("top_dead", int'(dead), 1);
`endif
    repeat (3) @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
